// File: rtl/stochastic_unit_sampler_pkg.sv
// Shared types and width helpers for the RBM stochastic unit sampler.
// The default bitlength must track the LFSR random generator width.
package stochastic_unit_sampler_pkg;

  localparam int DEFAULT_BITLENGTH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } sampler_state_t;

  // ones_count must be able to represent every value 0..n inclusive
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int index_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/stochastic_unit_sampler.sv
// Draws one Bernoulli sample per accepted probability and packs N_UNITS of
// them into a state vector with a running count of active units.
module stochastic_unit_sampler
  import stochastic_unit_sampler_pkg::*;
#(
  parameter int bitlength = DEFAULT_BITLENGTH,
  parameter int N_UNITS   = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [bitlength-1:0]             rand_in,
  input  logic                             prob_valid,
  output logic                             prob_ready,
  input  logic [bitlength-1:0]             prob_data,
  output logic                             sample_valid,
  input  logic                             sample_ready,
  output logic [N_UNITS-1:0]               sample_vec,
  output logic [count_width(N_UNITS)-1:0]  ones_count,
  output logic [index_width(N_UNITS)-1:0]  unit_idx
);

  localparam int CW = count_width(N_UNITS);
  localparam int IW = index_width(N_UNITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_UNITS - 1);

  sampler_state_t  state_reg;
  logic [IW-1:0]   idx_reg;
  logic [CW-1:0]   count_reg;
  logic            valid_reg;
  logic            ready_reg;

  logic            accept;
  logic            sample_bit;
  logic            handoff;

  // ready_reg is set during reset so the first post-reset cycle can accept;
  // the reset term masks it while reset is still asserted.
  assign prob_ready   = ready_reg & ~reset;
  assign sample_valid = valid_reg;
  assign accept       = prob_valid & prob_ready;
  assign handoff      = (state_reg == OUTPUT) & sample_ready;
  assign ones_count   = count_reg;
  assign unit_idx     = idx_reg;

  // All-ones is treated as certainty, otherwise strict unsigned compare.
  always_comb begin
    sample_bit = (&prob_data) | (rand_in < prob_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= COLLECT;
      idx_reg   <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        COLLECT: begin
          if (accept) begin
            count_reg <= count_reg + CW'(sample_bit);
            if (idx_reg == LAST_IDX) begin
              idx_reg   <= '0;
              state_reg <= OUTPUT;
              valid_reg <= 1'b1;
              ready_reg <= 1'b0;
            end else begin
              idx_reg <= idx_reg + 1'b1;
            end
          end
        end
        OUTPUT: begin
          if (sample_ready) begin
            state_reg <= COLLECT;
            count_reg <= '0;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= COLLECT;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // Each vector bit owns its register; it loads only when its slot is addressed.
  for (genvar gi = 0; gi < N_UNITS; gi++) begin : g_bits
    logic bit_reg;

    always_ff @(posedge clk) begin
      if (reset || handoff) begin
        bit_reg <= 1'b0;
      end else if (accept && (idx_reg == IW'(gi))) begin
        bit_reg <= sample_bit;
      end
    end

    assign sample_vec[gi] = bit_reg;
  end

endmodule
